// File: rtl/multi_table_init.sv
// Init/scrub engine: writes a fill word over an address range on a subset of table channels.
// Latency: CHECK one cycle after accept, first write 1-2 cycles later, result the cycle after the last write.
// Backpressure: wr_ready_i stalls the write counter; the result is held until result_ready_i.
module multi_table_init #(
    parameter int N_CH    = 2,
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 32,
    parameter int CMD_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               task_valid_i,
    output logic               task_ready_o,
    input  logic [CMD_W-1:0]   task_cmd_i,
    input  logic               task_mode_i,
    input  logic [N_CH-1:0]    task_ch_mask_i,
    input  logic [A_WIDTH-1:0] task_start_i,
    input  logic [A_WIDTH-1:0] task_end_i,
    input  logic [D_WIDTH-1:0] task_fill_i,
    output logic [N_CH-1:0]    wr_en_o,
    output logic [A_WIDTH-1:0] wr_addr_o,
    output logic [D_WIDTH-1:0] wr_data_o,
    input  logic               wr_ready_i,
    output logic               empty_ptr_storage_srst_o,
    output logic [A_WIDTH-1:0] add_empty_ptr_o,
    output logic               add_empty_ptr_en_o,
    output logic [CMD_W-1:0]   result_cmd_o,
    output logic [1:0]         result_rescode_o,
    output logic [A_WIDTH:0]   result_words_o,
    output logic               result_valid_o,
    input  logic               result_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RESET_EPS, S_FILL, S_REPORT
    } state_t;

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic               mode;
        logic [N_CH-1:0]    mask;
        logic [A_WIDTH-1:0] first;
        logic [A_WIDTH-1:0] last;
        logic [D_WIDTH-1:0] fill;
    } task_t;

    localparam logic [1:0] RC_OK        = 2'd0;
    localparam logic [1:0] RC_BAD_RANGE = 2'd1;
    localparam logic [1:0] RC_EMPTY     = 2'd2;

    state_t             state_q, state_d;
    task_t              task_q;
    logic [A_WIDTH:0]   cnt_q;
    logic [1:0]         rescode_q;
    logic [A_WIDTH:0]   words_q;
    logic               accept;
    logic               last_wr;
    logic               seed_eps;

    assign accept   = (state_q == S_IDLE) && task_valid_i;
    // The counter is one bit wider than the address so an all-ones end needs no wrap handling.
    assign last_wr  = (state_q == S_FILL) && wr_ready_i && (cnt_q == {1'b0, task_q.last});
    assign seed_eps = ~task_q.mode & task_q.mask[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (task_valid_i) state_d = S_CHECK;
            S_CHECK: begin
                if (task_q.mask == '0)               state_d = S_REPORT;
                else if (task_q.first > task_q.last) state_d = S_REPORT;
                else if (seed_eps)                   state_d = S_RESET_EPS;
                else                                 state_d = S_FILL;
            end
            S_RESET_EPS: state_d = S_FILL;
            S_FILL:      if (last_wr) state_d = S_REPORT;
            S_REPORT:    if (result_ready_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        task_ready_o             = 1'b0;
        wr_en_o                  = '0;
        empty_ptr_storage_srst_o = 1'b0;
        add_empty_ptr_en_o       = 1'b0;
        result_valid_o           = 1'b0;
        case (state_q)
            S_IDLE:      task_ready_o = 1'b1;
            S_RESET_EPS: empty_ptr_storage_srst_o = 1'b1;
            S_FILL: begin
                wr_en_o            = task_q.mask;
                // RANGE tasks must not add pointers: those addresses may already be live.
                add_empty_ptr_en_o = seed_eps & wr_ready_i;
            end
            S_REPORT:    result_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            task_q    <= '0;
            cnt_q     <= '0;
            rescode_q <= RC_OK;
            words_q   <= '0;
        end else begin
            if (accept) begin
                task_q.cmd   <= task_cmd_i;
                task_q.mode  <= task_mode_i;
                task_q.mask  <= task_ch_mask_i;
                task_q.first <= task_mode_i ? task_start_i : '0;
                task_q.last  <= task_mode_i ? task_end_i   : '1;
                task_q.fill  <= task_mode_i ? task_fill_i  : '0;
            end
            if (state_q == S_CHECK) begin
                if (task_q.mask == '0) begin
                    rescode_q <= RC_EMPTY;
                    words_q   <= '0;
                end else if (task_q.first > task_q.last) begin
                    rescode_q <= RC_BAD_RANGE;
                    words_q   <= '0;
                end else begin
                    rescode_q <= RC_OK;
                    words_q   <= {1'b0, task_q.last} - {1'b0, task_q.first}
                                 + {{A_WIDTH{1'b0}}, 1'b1};
                end
            end
            if ((state_d == S_FILL) && (state_q != S_FILL)) begin
                cnt_q <= {1'b0, task_q.first};
            end else if ((state_q == S_FILL) && wr_ready_i && !last_wr) begin
                cnt_q <= cnt_q + {{A_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

    assign wr_addr_o        = cnt_q[A_WIDTH-1:0];
    assign wr_data_o        = task_q.fill;
    assign add_empty_ptr_o  = cnt_q[A_WIDTH-1:0];
    assign result_cmd_o     = task_q.cmd;
    assign result_rescode_o = rescode_q;
    assign result_words_o   = words_q;

endmodule

// File: tb/tb_multi_table_init.sv
// Randomised scoreboard bench for multi_table_init with directed timing and reset cases.
module tb_multi_table_init;
    localparam int N_CH = 2;
    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int CW   = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            task_valid_i;
    logic            task_ready_o;
    logic [CW-1:0]   task_cmd_i;
    logic            task_mode_i;
    logic [N_CH-1:0] task_ch_mask_i;
    logic [AW-1:0]   task_start_i;
    logic [AW-1:0]   task_end_i;
    logic [DW-1:0]   task_fill_i;
    logic [N_CH-1:0] wr_en_o;
    logic [AW-1:0]   wr_addr_o;
    logic [DW-1:0]   wr_data_o;
    logic            wr_ready_i;
    logic            empty_ptr_storage_srst_o;
    logic [AW-1:0]   add_empty_ptr_o;
    logic            add_empty_ptr_en_o;
    logic [CW-1:0]   result_cmd_o;
    logic [1:0]      result_rescode_o;
    logic [AW:0]     result_words_o;
    logic            result_valid_o;
    logic            result_ready_i;

    multi_table_init #(.N_CH(N_CH), .A_WIDTH(AW), .D_WIDTH(DW), .CMD_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
        .task_cmd_i(task_cmd_i), .task_mode_i(task_mode_i),
        .task_ch_mask_i(task_ch_mask_i), .task_start_i(task_start_i),
        .task_end_i(task_end_i), .task_fill_i(task_fill_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_ready_i(wr_ready_i),
        .empty_ptr_storage_srst_o(empty_ptr_storage_srst_o),
        .add_empty_ptr_o(add_empty_ptr_o), .add_empty_ptr_en_o(add_empty_ptr_en_o),
        .result_cmd_o(result_cmd_o), .result_rescode_o(result_rescode_o),
        .result_words_o(result_words_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [AW-1:0] addr; logic [N_CH-1:0] en; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [CW-1:0] cmd; logic [1:0] rc; logic [AW:0] words; } res_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_ptr[$];
    res_t          exp_res[$];
    int            exp_srst = 0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            first_wr_cyc = -1;
    int            srst_cyc = -1;
    int            wr_mode = 0;   // 0 always ready, 1 toggling, 2 random
    int            res_mode = 0;  // 0 always ready, 1 random, 2 held low
    logic          tog = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #2;
        tog = ~tog;
        case (wr_mode)
            0: wr_ready_i = 1'b1;
            1: wr_ready_i = tog;
            default: wr_ready_i = 1'($urandom % 2);
        endcase
        case (res_mode)
            0: result_ready_i = 1'b1;
            1: result_ready_i = ($urandom_range(0, 3) != 0);
            default: result_ready_i = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or missing (t=%0t)", name, $time);
    endtask

    // Reference behaviour: expand a task into its list of writes, pointer adds and result.
    task automatic push_model(input logic [CW-1:0] cmd, input bit mode, input logic [N_CH-1:0] mask,
                              input int s, input int e, input logic [DW-1:0] fill);
        res_t r;
        wr_t  w;
        bit   seed;
        if (mode == 0) begin s = 0; e = (1 << AW) - 1; fill = '0; end
        seed = (mode == 0) && mask[0];
        r.cmd = cmd;
        if (mask == 0) begin
            r.rc = 2'd2; r.words = '0;
        end else if (s > e) begin
            r.rc = 2'd1; r.words = '0;
        end else begin
            r.rc = 2'd0; r.words = (AW+1)'(e - s + 1);
            if (seed) exp_srst++;
            for (int a = s; a <= e; a++) begin
                w.addr = AW'(a); w.en = mask; w.data = fill;
                exp_wr.push_back(w);
                if (seed) exp_ptr.push_back(AW'(a));
            end
        end
        exp_res.push_back(r);
    endtask

    always @(negedge clk_i) begin : monitor
        wr_t  w;
        res_t r;
        if (!rst_i) begin
            if (|wr_en_o) begin
                if (exp_wr.size() == 0) fail("unexpected_write");
                else if (wr_ready_i) begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(wr_addr_o), 64'(w.addr));
                    chk("wr_en", 64'(wr_en_o), 64'(w.en));
                    chk("wr_data", 64'(wr_data_o), 64'(w.data));
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                end else begin
                    chk("stalled_addr", 64'(wr_addr_o), 64'(exp_wr[0].addr));
                end
            end
            if (add_empty_ptr_en_o) begin
                if (exp_ptr.size() == 0) fail("unexpected_ptr_add");
                else chk("ptr_addr", 64'(add_empty_ptr_o), 64'(exp_ptr.pop_front()));
            end
            if (empty_ptr_storage_srst_o) begin
                if (exp_srst == 0) fail("unexpected_srst");
                else begin exp_srst--; srst_cyc = cyc; end
            end
            if (result_valid_o && result_ready_i) begin
                if (exp_res.size() == 0) fail("unexpected_result");
                else begin
                    r = exp_res.pop_front();
                    chk("res_cmd", 64'(result_cmd_o), 64'(r.cmd));
                    chk("res_rescode", 64'(result_rescode_o), 64'(r.rc));
                    chk("res_words", 64'(result_words_o), 64'(r.words));
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_task_ready"}, 64'(task_ready_o), 64'd1);
        chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
        chk({tag, "_srst"}, 64'(empty_ptr_storage_srst_o), 64'd0);
        chk({tag, "_ptr_en"}, 64'(add_empty_ptr_en_o), 64'd0);
        chk({tag, "_ptr"}, 64'(add_empty_ptr_o), 64'd0);
        chk({tag, "_res_valid"}, 64'(result_valid_o), 64'd0);
        chk({tag, "_res_cmd"}, 64'(result_cmd_o), 64'd0);
        chk({tag, "_res_rc"}, 64'(result_rescode_o), 64'd0);
        chk({tag, "_res_words"}, 64'(result_words_o), 64'd0);
    endtask

    task automatic issue(input logic [CW-1:0] cmd, input bit mode, input logic [N_CH-1:0] mask,
                         input int s, input int e, input logic [DW-1:0] fill, output int acc);
        push_model(cmd, mode, mask, s, e, fill);
        first_wr_cyc = -1;
        srst_cyc = -1;
        @(posedge clk_i); #1;
        task_valid_i = 1'b1; task_cmd_i = cmd; task_mode_i = mode; task_ch_mask_i = mask;
        task_start_i = AW'(s); task_end_i = AW'(e); task_fill_i = fill;
        chk("task_ready_idle", 64'(task_ready_o), 64'd1);
        @(posedge clk_i); #1;
        acc = cyc;
        task_valid_i = 1'b0;
        task_start_i = AW'($urandom); task_end_i = AW'($urandom); task_fill_i = $urandom;
        chk("task_ready_busy", 64'(task_ready_o), 64'd0);
    endtask

    task automatic wait_valid(input int acc, output int rel);
        bit got = 0;
        rel = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (result_valid_o) begin got = 1; break; end
        end
        if (!got) fail("result_timeout");
        else rel = cyc - acc + 1;
    endtask

    task automatic wait_handshake;
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            if (result_valid_o && result_ready_i) begin got = 1; break; end
            @(negedge clk_i);
        end
        if (!got) fail("handshake_timeout");
        @(posedge clk_i); #1;
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("ptr_queue_drained", 64'(exp_ptr.size()), 64'd0);
        chk("srst_drained", 64'(exp_srst), 64'd0);
    endtask

    task automatic run_task(input logic [CW-1:0] cmd, input bit mode, input logic [N_CH-1:0] mask,
                            input int s, input int e, input logic [DW-1:0] fill, output int acc,
                            output int rel);
        issue(cmd, mode, mask, s, e, fill, acc);
        wait_valid(acc, rel);
        wait_handshake();
    endtask

    initial begin
        int acc, rel;
        rst_i = 1'b1; task_valid_i = 1'b0; task_cmd_i = '0; task_mode_i = 1'b0;
        task_ch_mask_i = '0; task_start_i = '0; task_end_i = '0; task_fill_i = '0;
        wr_ready_i = 1'b1; result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk_reset("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;

        // FULL, no stalls: srst at T+2, writes T+3..T+18, result at T+19
        run_task(4'h1, 1'b0, 2'b11, 9, 2, 32'hDEAD_BEEF, acc, rel);
        chk("full_valid_cycle", 64'(rel), 64'd19);
        chk("full_srst_cycle", 64'(srst_cyc - acc + 1), 64'd2);
        chk("full_first_wr_cycle", 64'(first_wr_cyc - acc + 1), 64'd3);

        run_task(4'h2, 1'b1, 2'b10, 3, 5, 32'hA5A5_A5A5, acc, rel);
        chk("range_valid_cycle", 64'(rel), 64'd5);
        chk("range_first_wr_cycle", 64'(first_wr_cyc - acc + 1), 64'd2);
        chk("range_no_srst", 64'(srst_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        run_task(4'h3, 1'b1, 2'b11, 5, 3, 32'h1234_5678, acc, rel);
        chk("bad_range_valid_cycle", 64'(rel), 64'd2);
        run_task(4'h4, 1'b0, 2'b00, 0, 15, 32'h0, acc, rel);
        chk("empty_mask_valid_cycle", 64'(rel), 64'd2);

        wr_mode = 1;
        run_task(4'h5, 1'b0, 2'b01, 0, 0, 32'h0, acc, rel);
        wr_mode = 0;

        // Result held back: fields stable, no new task taken
        res_mode = 2;
        issue(4'h6, 1'b1, 2'b01, 0, 1, 32'h0BAD_F00D, acc);
        wait_valid(acc, rel);
        #1;
        task_valid_i = 1'b1; task_cmd_i = 4'hF; task_mode_i = 1'b1; task_ch_mask_i = 2'b11;
        task_start_i = '0; task_end_i = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("hold_valid", 64'(result_valid_o), 64'd1);
            chk("hold_task_ready", 64'(task_ready_o), 64'd0);
            chk("hold_cmd", 64'(result_cmd_o), 64'h6);
            chk("hold_rc", 64'(result_rescode_o), 64'd0);
            chk("hold_words", 64'(result_words_o), 64'd2);
        end
        @(posedge clk_i); #1;
        task_valid_i = 1'b0;
        res_mode = 0;
        wait_handshake();

        // Reset in the middle of FILL
        issue(4'h8, 1'b0, 2'b11, 0, 15, 32'h0, acc);
        begin
            bit got = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_i);
                if ((|wr_en_o) && wr_addr_o == 4'd7) begin got = 1; break; end
            end
            if (!got) fail("addr7_timeout");
        end
        rst_i = 1'b1;
        #1;
        chk_reset("midrst");
        exp_wr.delete(); exp_ptr.delete(); exp_res.delete(); exp_srst = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;
        run_task(4'h9, 1'b0, 2'b11, 0, 0, 32'h0, acc, rel);
        chk("post_rst_srst_cycle", 64'(srst_cyc - acc + 1), 64'd2);
        chk("post_rst_valid_cycle", 64'(rel), 64'd19);

        wr_mode = 2;
        res_mode = 1;
        for (int n = 0; n < 30; n++) begin
            run_task(CW'($urandom), 1'($urandom), N_CH'($urandom),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom, acc, rel);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
